// File: rtl/uart_fifo_pkg.sv
// Shared FIFO defaults and entry type for the UART TX holding / RX buffer datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FIFO_DATA_WIDTH, FIFO_DEPTH, FIFO_AF_LEVEL defaults and fifo_data_t.
package uart_fifo_pkg;

   // Entry = data[7:0] plus parity/framing/break status in [10:8]
   localparam int FIFO_DATA_WIDTH = 11;
   localparam int FIFO_DEPTH      = 16;
   localparam int FIFO_AF_LEVEL   = 14;

   typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;

endpackage

// File: rtl/uart_fifo_if.sv
// FIFO bus between a UART producer/consumer and the FIFO (push side and pop side).
// Latency: wires only.
// Backpressure: producer watches full/almost_full; consumer watches empty.
// Signals: push/push_dat (write), pop/pop_dat (show-ahead read), empty/full/almost_full.
interface uart_fifo_if
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

   logic                  push;
   logic [DATA_WIDTH-1:0] push_dat;
   logic                  pop;
   logic [DATA_WIDTH-1:0] pop_dat;
   logic                  empty;
   logic                  full;
   logic                  almost_full;

   modport push_master_mp (output push, push_dat);
   modport push_slave_mp  (input  push, push_dat);

   modport pop_master_mp  (output pop, input  pop_dat, empty, full, almost_full);
   modport pop_slave_mp   (input  pop, output pop_dat, empty, full, almost_full);

endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_WIDTH storage array for uart_fifo.
// Latency: write lands at the clock edge; read is combinational from raddr_i.
// Backpressure: none; the controller decides when we_i is allowed.
// Ports: clk_i, we_i, waddr_i, wdata_i (write port); raddr_i -> rdata_o (read port).
module uart_fifo_ram
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Contents are never reset; the controller masks stale data via empty
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO for UART TX holding / RX buffer entries.
// Latency: pushed entry visible on pop_dat one edge after push into an empty FIFO; flags registered.
// Backpressure: push on full dropped unless a pop is accepted the same edge; pop on empty ignored.
// Ports: clk_i, rst_i (async, high), clear_i (sync flush), wr (push side), rd (pop side + flags).
module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int AF_LEVEL   = FIFO_AF_LEVEL
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   uart_fifo_if.push_slave_mp wr,
   uart_fifo_if.pop_slave_mp  rd
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  af_q, af_d;
   logic                  push_acc, pop_acc, ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // A pop frees a slot in the same edge, so a full FIFO may still take a push
   assign pop_acc  = rd.pop && !empty_q;
   assign push_acc = wr.push && (!full_q || pop_acc);
   assign ram_we   = push_acc && !clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_acc && !pop_acc) begin
            count_d = count_q + CW'(1);
         end else if (pop_acc && !push_acc) begin
            count_d = count_q - CW'(1);
         end
      end
      // Flags come from the next count so they are valid right after the edge
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
      af_d    = (count_d >= CW'(AF_LEVEL));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         af_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         af_q     <= af_d;
      end
   end

   uart_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr.push_dat),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // Head is forced to zero while empty so stale RAM data never leaks out
   assign rd.pop_dat     = empty_q ? '0 : ram_rdata;
   assign rd.empty       = empty_q;
   assign rd.full        = full_q;
   assign rd.almost_full = af_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: scoreboard queue of expected entries,
// flags checked against the scoreboard occupancy after every edge.
// Single clock, inputs driven 1 time unit after the rising edge.
module tb_uart_fifo;
   import uart_fifo_pkg::*;

   localparam int DEPTH = FIFO_DEPTH;
   localparam int AFL   = FIFO_AF_LEVEL;

   logic clk;
   logic rst;
   logic clr;

   int n_vec;
   int n_err;

   fifo_data_t sb_q[$];

   uart_fifo_if bus ();

   uart_fifo dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clr),
      .wr      (bus),
      .rd      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Flags and head against scoreboard occupancy
   task automatic chk_state(input string tag);
      int n;
      n = sb_q.size();
      chk({tag, ".empty"}, {31'd0, bus.empty},       {31'd0, (n == 0)});
      chk({tag, ".full"},  {31'd0, bus.full},        {31'd0, (n == DEPTH)});
      chk({tag, ".afull"}, {31'd0, bus.almost_full}, {31'd0, (n >= AFL)});
      if (n == 0) chk({tag, ".head"}, {21'd0, bus.pop_dat}, 32'd0);
      else        chk({tag, ".head"}, {21'd0, bus.pop_dat}, {21'd0, sb_q[0]});
   endtask

   // One clock: model the accept rules, drive strobes, check after the edge
   task automatic cyc(input logic p, input fifo_data_t d, input logic q, input logic c,
                      input string tag);
      int  n;
      logic pop_ok, push_ok;
      n       = sb_q.size();
      pop_ok  = q && (n > 0) && !c;
      push_ok = p && ((n < DEPTH) || pop_ok) && !c;
      if (pop_ok) begin
         chk({tag, ".pop"}, {21'd0, bus.pop_dat}, {21'd0, sb_q[0]});
         void'(sb_q.pop_front());
      end
      if (push_ok) sb_q.push_back(d);
      if (c) sb_q.delete();
      bus.push     = p;
      bus.push_dat = d;
      bus.pop      = q;
      clr          = c;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      clr      = 1'b0;
      chk_state(tag);
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      rst          = 1'b1;
      clr          = 1'b0;
      bus.push     = 1'b0;
      bus.push_dat = '0;
      bus.pop      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("rst0");
      rst = 1'b0;

      // 1: async reset mid-clock with data stored
      cyc(1'b1, 11'h123, 1'b0, 1'b0, "pre_rst");
      cyc(1'b1, 11'h456, 1'b0, 1'b0, "pre_rst");
      #3;
      rst = 1'b1;
      #1;
      sb_q.delete();
      chk("rst_mid.empty", {31'd0, bus.empty},       32'd1);
      chk("rst_mid.full",  {31'd0, bus.full},        32'd0);
      chk("rst_mid.afull", {31'd0, bus.almost_full}, 32'd0);
      chk("rst_mid.dat",   {21'd0, bus.pop_dat},     32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 2: three entries in, three out in order
      cyc(1'b1, 11'h001, 1'b0, 1'b0, "t2_push");
      cyc(1'b1, 11'h155, 1'b0, 1'b0, "t2_push");
      cyc(1'b1, 11'h7FF, 1'b0, 1'b0, "t2_push");
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, "t2_pop");
      chk("t2_empty", {31'd0, bus.empty}, 32'd1);

      // 3: fill to full, overflow dropped, drain
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, fifo_data_t'(i), 1'b0, 1'b0, "t3_fill");
         if (i == AFL - 2) chk("t3_af_before", {31'd0, bus.almost_full}, 32'd0);
         if (i == AFL - 1) chk("t3_af_at",     {31'd0, bus.almost_full}, 32'd1);
      end
      chk("t3_full", {31'd0, bus.full}, 32'd1);
      cyc(1'b1, 11'h3AA, 1'b0, 1'b0, "t3_ovf");
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, "t3_drain");

      // 4: pop on empty ignored, then a push shows up on the head
      cyc(1'b0, '0, 1'b1, 1'b0, "t4_udf");
      chk("t4_empty", {31'd0, bus.empty}, 32'd1);
      cyc(1'b1, 11'h042, 1'b0, 1'b0, "t4_push");
      chk("t4_head", {21'd0, bus.pop_dat}, 32'h042);
      cyc(1'b0, '0, 1'b1, 1'b0, "t4_pop");

      // 5: push+pop on full keeps full, new entry is last out
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, fifo_data_t'(11'h100 + i), 1'b0, 1'b0, "t5_fill");
      cyc(1'b1, 11'h0AB, 1'b1, 1'b0, "t5_both");
      chk("t5_full", {31'd0, bus.full}, 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) chk("t5_last", {21'd0, bus.pop_dat}, 32'h0AB);
         cyc(1'b0, '0, 1'b1, 1'b0, "t5_drain");
      end

      // 6: synchronous clear flushes, push/pop on that edge ignored
      for (int i = 0; i < 5; i++) cyc(1'b1, fifo_data_t'(11'h200 + i), 1'b0, 1'b0, "t6_fill");
      cyc(1'b1, 11'h7EE, 1'b1, 1'b1, "t6_clr");
      chk("t6_empty", {31'd0, bus.empty}, 32'd1);
      cyc(1'b1, 11'h011, 1'b0, 1'b0, "t6_push");
      chk("t6_head", {21'd0, bus.pop_dat}, 32'h011);
      cyc(1'b0, '0, 1'b1, 1'b0, "t6_pop");

      // Random traffic including back-to-back strobes
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), fifo_data_t'($urandom_range(0, 2047)),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0), "rnd");
      end
      while (sb_q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0, "rnd_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
